// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state and access-size encodings for the data-memory bridge.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
endpackage

// File: rtl/dmem_bridge_load_align.sv
// load_align: selects the addressed lane of a bus read word and sign/zero-extends it.
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    logic [31:0] w_shb;
    logic [31:0] w_shh;
    logic        w_sign;
    assign w_shb  = i_rdata >> {i_addr, 3'b000};
    assign w_shh  = i_rdata >> {i_addr[1], 4'b0000};
    assign w_sign = ~i_funct3[2];
    // Size 11 only reaches here with trapping disabled; it reads as a word.
    assign o_data = (i_funct3[1:0] == SZ_B) ? {{24{w_sign & w_shb[7]}}, w_shb[7:0]} :
                    (i_funct3[1:0] == SZ_H) ? {{16{w_sign & w_shh[15]}}, w_shh[15:0]} :
                    i_rdata;
endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: RV32I load/store bridge onto a valid/grant data bus, one access in flight.
// Define DMEM_MISALIGN_TRAP_EN to complete misaligned/illegal accesses locally with err_o.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        we_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              d_req_o,
    input  logic              d_gnt_i,
    output logic [ADDR_W-1:0] d_addr_o,
    output logic [3:0]        d_we_o,
    output logic [31:0]       d_wdata_o,
    input  logic              d_rvalid_i,
    input  logic [31:0]       d_rdata_i
);
    state_e            r_state;
    state_e            w_next;
    logic              r_write;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic [31:0]       w_load;
    logic              w_misalign;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = (funct3_i[1:0] == SZ_H && addr_i[0]) ||
                        (funct3_i[1:0] == SZ_W && addr_i[1:0] != 2'b00) ||
                        (funct3_i[1:0] == 2'b11);
`else
    assign w_misalign = 1'b0;
`endif

    load_align u_load_align (
        .i_rdata  (d_rdata_i),
        .i_addr   (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_data   (w_load)
    );

    always_comb begin
        w_next  = r_state;
        d_req_o = 1'b0;
        done_o  = 1'b0;
        unique case (r_state)
            IDLE: w_next = req_i ? (w_misalign ? DONE : REQ) : IDLE;
            REQ: begin
                d_req_o = 1'b1;
                w_next  = d_gnt_i ? (r_write ? DONE : RESP) : REQ;
            end
            RESP: w_next = d_rvalid_i ? DONE : RESP;
            DONE: begin
                done_o = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_write  <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req_i) begin
                r_write  <= mem_write_i;
                r_funct3 <= funct3_i;
                r_addr   <= addr_i;
                r_wdata  <= wdata_i;
                r_be     <= we_i;
                r_err    <= w_misalign;
            end
            if (r_state == RESP && d_rvalid_i) r_rdata <= w_load;
        end
    end

    assign stall_o   = req_i & ~done_o;
    assign err_o     = done_o & r_err;
    assign rdata_o   = r_rdata;
    assign d_addr_o  = {r_addr[ADDR_W-1:2], 2'b00};
    assign d_we_o    = (r_state == REQ && r_write) ? r_be : 4'b0000;
    assign d_wdata_o = (r_funct3[1:0] == SZ_B) ? {4{r_wdata[7:0]}} :
                       (r_funct3[1:0] == SZ_H) ? {2{r_wdata[15:0]}} : r_wdata;
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed accesses with queued expectations checked by done/bus monitors.
module tb_dmem_bridge;
    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [3:0]  we_i = '0;
    logic        stall_o, done_o, err_o, d_req_o;
    logic [31:0] rdata_o, d_addr_o, d_wdata_o;
    logic [3:0]  d_we_o;
    logic        d_gnt_i = 1'b0;
    logic        d_rvalid_i = 1'b0;
    logic [31:0] d_rdata_i = '0;

    typedef struct {logic [31:0] rdata; logic err; int cyc;} exp_t;
    typedef struct {logic [31:0] addr; logic [3:0] we; logic [31:0] wdata;} bus_t;
    exp_t eq[$];
    bus_t bq[$];
    exp_t me;
    bus_t mb;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int gnt_dly = 0, rv_dly = 0, gcnt = 0, rcnt = 0;
    bit cur_write = 0, rpend = 0, stray_gnt = 0, stray_rv = 0;
    logic [31:0] rword = '0;

    dmem_bridge #(.ADDR_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .mem_write_i(mem_write_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .we_i(we_i),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
        .d_req_o(d_req_o), .d_gnt_i(d_gnt_i), .d_addr_o(d_addr_o), .d_we_o(d_we_o),
        .d_wdata_o(d_wdata_o), .d_rvalid_i(d_rvalid_i), .d_rdata_i(d_rdata_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus slave: grants after gnt_dly waiting cycles, answers loads after rv_dly more.
    initial forever begin
        @(negedge clk);
        d_gnt_i = stray_gnt;
        d_rvalid_i = stray_rv;
        if (!rst_ni) begin
            gcnt = 0; rcnt = 0; rpend = 0;
        end else if (rpend) begin
            if (rcnt == rv_dly) begin
                d_rvalid_i = 1'b1; d_rdata_i = rword; rpend = 0; rcnt = 0;
            end else rcnt++;
        end else if (d_req_o) begin
            if (gcnt == gnt_dly) begin
                d_gnt_i = 1'b1; gcnt = 0; rpend = !cur_write;
                if (bq.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_bus_beat: addr %h we %b", d_addr_o, d_we_o);
                end else begin
                    mb = bq.pop_front();
                    chk("d_addr_o", d_addr_o, mb.addr);
                    chk("d_we_o", {28'b0, d_we_o}, {28'b0, mb.we});
                    chk("d_wdata_o", d_wdata_o, mb.wdata);
                end
            end else gcnt++;
        end
    end

    always @(negedge clk) if (rst_ni && done_o) begin
        if (eq.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_done: got done_o=1 expected no completion (cycle %0d)", cyc);
        end else begin
            me = eq.pop_front();
            chk("done_cycle", cyc, me.cyc);
            chk("rdata_o", rdata_o, me.rdata);
            chk("err_o", {31'b0, err_o}, {31'b0, me.err});
        end
    end

    task automatic access(input bit w, input logic [2:0] f3, input logic [31:0] a, wd,
                          input logic [3:0] we, input logic [31:0] rw, input int gd, rd,
                          input bit hold, input logic [31:0] exp_rd, input bit exp_err,
                          input int lat, input bit bus, input logic [31:0] ea,
                          input logic [3:0] ewe, input logic [31:0] ewd);
        exp_t e;
        bus_t b;
        @(posedge clk); #1;
        cur_write = w; gnt_dly = gd; rv_dly = rd; rword = rw;
        e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc + lat;
        eq.push_back(e);
        if (bus) begin
            b.addr = ea; b.we = ewe; b.wdata = ewd;
            bq.push_back(b);
        end
        req_i = 1'b1; mem_write_i = w; funct3_i = f3; addr_i = a; wdata_i = wd; we_i = we;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            chk("stall_o", {31'b0, stall_o}, {31'b0, (n < lat) && (hold || n == 0)});
            if (done_o) break;
            if (n >= 40) begin
                n_cmp++; n_fail++;
                $display("FAIL done_timeout: got no done_o expected one at cycle %0d", e.cyc);
                break;
            end
            @(posedge clk); #1;
            if (!hold) begin
                req_i = 1'b0; addr_i = 32'hFFFF_FFFF; wdata_i = ~wd; we_i = ~we; mem_write_i = ~w;
            end
        end
        @(posedge clk); #1;
        req_i = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_d_req", {31'b0, d_req_o}, 0);
        chk("rst_done", {31'b0, done_o}, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_d_addr", d_addr_o, 0);
        chk("rst_d_we", {28'b0, d_we_o}, 0);
        chk("rst_d_wdata", d_wdata_o, 0);
        chk("rst_err", {31'b0, err_o}, 0);
        chk("rst_stall_lo", {31'b0, stall_o}, 0);
        req_i = 1'b1; #1;
        chk("rst_stall_hi", {31'b0, stall_o}, 1);
        req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;

        // w  f3      addr         wdata         we     rword         gd rd hold exp_rdata     err lat bus eaddr        ewe    ewdata
        access(0, 3'b000, 32'h103, 32'h0,         4'h0, 32'h80FF_0000, 0, 0, 1, 32'hFFFF_FF80, 0, 3, 1, 32'h100, 4'h0, 32'h0);
        access(0, 3'b101, 32'h102, 32'h0,         4'h0, 32'h9234_0000, 0, 0, 1, 32'h0000_9234, 0, 3, 1, 32'h100, 4'h0, 32'h0);
        access(1, 3'b000, 32'h201, 32'h1234_56AB, 4'h2, 32'h0,         0, 0, 1, 32'h0000_9234, 0, 2, 1, 32'h200, 4'h2, 32'hABAB_ABAB);
        access(0, 3'b010, 32'h400, 32'h0,         4'h0, 32'hDEAD_BEEF, 2, 3, 1, 32'hDEAD_BEEF, 0, 8, 1, 32'h400, 4'h0, 32'h0);
        access(1, 3'b001, 32'h502, 32'hCAFE_BEEF, 4'hC, 32'h0,         1, 0, 0, 32'hDEAD_BEEF, 0, 3, 1, 32'h500, 4'hC, 32'hBEEF_BEEF);
        access(0, 3'b100, 32'h601, 32'h0,         4'h0, 32'h0000_A500, 0, 1, 1, 32'h0000_00A5, 0, 4, 1, 32'h600, 4'h0, 32'h0);
        access(0, 3'b001, 32'h700, 32'h0,         4'h0, 32'h0000_8001, 0, 0, 0, 32'hFFFF_8001, 0, 3, 1, 32'h700, 4'h0, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
        access(1, 3'b010, 32'h302, 32'h1122_3344, 4'hF, 32'h0,         0, 0, 1, 32'hFFFF_8001, 1, 1, 0, 32'h0,   4'h0, 32'h0);
        access(0, 3'b001, 32'h703, 32'h0,         4'h0, 32'h7FFF_0000, 0, 0, 1, 32'hFFFF_8001, 1, 1, 0, 32'h0,   4'h0, 32'h0);
`else
        access(1, 3'b010, 32'h302, 32'h1122_3344, 4'hF, 32'h0,         0, 0, 1, 32'hFFFF_8001, 0, 2, 1, 32'h300, 4'hF, 32'h1122_3344);
        access(0, 3'b001, 32'h703, 32'h0,         4'h0, 32'h7FFF_0000, 0, 0, 1, 32'h0000_7FFF, 0, 3, 1, 32'h700, 4'h0, 32'h0);
`endif

        // Reset while the load waits in RESP: no completion, no late capture.
        @(posedge clk); #1;
        cur_write = 0; gnt_dly = 0; rv_dly = 20; rword = 32'h5555_5555;
        mb.addr = 32'h800; mb.we = 4'h0; mb.wdata = 32'h0;
        bq.push_back(mb);
        req_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h800; wdata_i = '0; we_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b0; req_i = 1'b0;
        #1;
        chk("rstmid_d_req", {31'b0, d_req_o}, 0);
        chk("rstmid_done", {31'b0, done_o}, 0);
        chk("rstmid_stall", {31'b0, stall_o}, 0);
        chk("rstmid_rdata", rdata_o, 0);
        @(posedge clk); #1 rst_ni = 1'b1;
        stray_rv = 1; stray_gnt = 1; d_rdata_i = 32'h1357_9BDF;
        repeat (3) begin
            @(negedge clk); #1;
            chk("stray_d_req", {31'b0, d_req_o}, 0);
            chk("stray_rdata", rdata_o, 0);
        end
        stray_rv = 0; stray_gnt = 0;
        repeat (4) @(posedge clk);
        chk("exp_queue_drained", eq.size(), 0);
        chk("bus_queue_drained", bq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by time %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
